// File: rtl/sga_render_pkg.sv
// rtl/sga_render_pkg.sv - shared sizes, capture FSM encoding and position helpers for the matrix renderer
//
// Contents:
//   ROWS, COLS, POS_W  - frame geometry and packed position width
//   cap_state_e        - capture FSM state encoding
//   pos_row / pos_col  - split a {row[5:3], col[2:0]} position
package sga_render_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int POS_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMMIT  = 2'd2
    } cap_state_e;

    function automatic logic [2:0] pos_row(input logic [POS_W-1:0] pos);
        return pos[5:3];
    endfunction

    function automatic logic [2:0] pos_col(input logic [POS_W-1:0] pos);
        return pos[2:0];
    endfunction

endpackage

// File: rtl/sga_row_scan.sv
// rtl/sga_row_scan.sv - row hold counter and row index for the multiplexed LED scan
//
// Ports:
//   clock_i, reset_n_i - clock, asynchronous active-low reset
//   row_idx_o          - row index that will be selected after the coming edge
//   row_sel_next_o     - one-hot form of row_idx_o, registered by the top
//   wrap_o             - high in the cycle whose edge moves the scan from row 7 to row 0
module sga_row_scan
    import sga_render_pkg::*;
#(
    parameter int ROW_HOLD = 50000,
    parameter int HOLD_W   = 16
) (
    input  logic            clock_i,
    input  logic            reset_n_i,
    output logic [2:0]      row_idx_o,
    output logic [ROWS-1:0] row_sel_next_o,
    output logic            wrap_o
);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]        row_q, row_d;
    logic              advance;

    always_comb begin
        advance = (hold_q == HOLD_W'(ROW_HOLD - 1));
        hold_d  = advance ? '0 : hold_q + HOLD_W'(1);
        row_d   = advance ? row_q + 3'd1 : row_q;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_q <= '0;
            row_q  <= '0;
        end else begin
            hold_q <= hold_d;
            row_q  <= row_d;
        end
    end

    // The top registers its outputs from these, so they describe the row
    // that becomes visible on the coming edge rather than the current one.
    assign row_idx_o      = row_d;
    assign row_sel_next_o = ROWS'(1) << row_d;
    assign wrap_o         = advance && (row_q == 3'd7);

endmodule

// File: rtl/sga_matrix_renderer.sv
// rtl/sga_matrix_renderer.sv - triple-buffered 8x8 snake/apple frame capture and bicolour LED row scan
//
// Ports:
//   clock_i, reset_n_i          - clock, asynchronous active-low reset
//   frame_start_i               - clear capture buffer and start a frame
//   seg_valid_i, seg_pos_i      - body segment {row, col} to mark in the capture buffer
//   apple_pos_i, frame_done_i   - end of render pass; apple sampled with frame_done_i
//   row_sel_o                   - one-hot row drive
//   col_snake_o, col_apple_o    - column data of both planes for the selected row
//   busy_o                      - capture in progress
//   frame_err_o                 - sticky: frame_done_i seen outside capture
module sga_matrix_renderer
    import sga_render_pkg::*;
#(
    parameter int ROW_HOLD = 50000,
    parameter int HOLD_W   = 16
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             frame_start_i,
    input  logic             seg_valid_i,
    input  logic [POS_W-1:0] seg_pos_i,
    input  logic [POS_W-1:0] apple_pos_i,
    input  logic             frame_done_i,
    output logic [ROWS-1:0]  row_sel_o,
    output logic [COLS-1:0]  col_snake_o,
    output logic [COLS-1:0]  col_apple_o,
    output logic             busy_o,
    output logic             frame_err_o
);

    cap_state_e                  state_q, state_d;
    logic [ROWS-1:0][COLS-1:0]   capture_q, capture_d;
    logic [ROWS-1:0][COLS-1:0]   committed_q, committed_d;
    logic [ROWS-1:0][COLS-1:0]   displayed_q, displayed_d;
    logic [POS_W-1:0]            apple_lat_q, apple_lat_d;
    logic [POS_W-1:0]            apple_reg_q, apple_reg_d;
    logic [POS_W-1:0]            apple_disp_q, apple_disp_d;
    logic                        disp_valid_q, disp_valid_d;
    logic                        pending_q, pending_d;
    logic                        err_q, err_d;
    logic                        busy_q;
    logic [ROWS-1:0]             row_sel_q;
    logic [COLS-1:0]             col_snake_q, col_snake_d;
    logic [COLS-1:0]             col_apple_q, col_apple_d;

    logic [2:0]                  row_idx;
    logic [ROWS-1:0]             row_sel_next;
    logic                        wrap;

    sga_row_scan #(
        .ROW_HOLD (ROW_HOLD),
        .HOLD_W   (HOLD_W)
    ) u_scan (
        .clock_i        (clock_i),
        .reset_n_i      (reset_n_i),
        .row_idx_o      (row_idx),
        .row_sel_next_o (row_sel_next),
        .wrap_o         (wrap)
    );

    always_comb begin
        state_d      = state_q;
        capture_d    = capture_q;
        committed_d  = committed_q;
        displayed_d  = displayed_q;
        apple_lat_d  = apple_lat_q;
        apple_reg_d  = apple_reg_q;
        apple_disp_d = apple_disp_q;
        disp_valid_d = disp_valid_q;
        pending_d    = pending_q;
        err_d        = err_q;

        // Swap is evaluated before the FSM so a commit landing on the wrap
        // edge re-arms pending for the following scan.
        if (wrap && pending_q) begin
            displayed_d  = committed_q;
            apple_disp_d = apple_reg_q;
            disp_valid_d = 1'b1;
            pending_d    = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_done_i && !frame_start_i) begin
                    err_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (seg_valid_i) begin
                    capture_d[pos_row(seg_pos_i)][pos_col(seg_pos_i)] = 1'b1;
                end
                if (frame_done_i) begin
                    state_d     = ST_COMMIT;
                    apple_lat_d = apple_pos_i;
                end
            end
            ST_COMMIT: begin
                committed_d = capture_q;
                apple_reg_d = apple_lat_q;
                pending_d   = 1'b1;
                state_d     = ST_IDLE;
                if (frame_done_i && !frame_start_i) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // frame_start overrides everything above except a commit already
        // underway, whose buffer copy was taken from capture_q.
        if (frame_start_i) begin
            capture_d = '0;
            state_d   = ST_CAPTURE;
        end

        col_snake_d = displayed_d[row_idx];
        col_apple_d = (disp_valid_d && pos_row(apple_disp_d) == row_idx)
                    ? (COLS'(1) << pos_col(apple_disp_d)) : '0;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            capture_q    <= '0;
            committed_q  <= '0;
            displayed_q  <= '0;
            apple_lat_q  <= '0;
            apple_reg_q  <= '0;
            apple_disp_q <= '0;
            disp_valid_q <= 1'b0;
            pending_q    <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            row_sel_q    <= ROWS'(1);
            col_snake_q  <= '0;
            col_apple_q  <= '0;
        end else begin
            state_q      <= state_d;
            capture_q    <= capture_d;
            committed_q  <= committed_d;
            displayed_q  <= displayed_d;
            apple_lat_q  <= apple_lat_d;
            apple_reg_q  <= apple_reg_d;
            apple_disp_q <= apple_disp_d;
            disp_valid_q <= disp_valid_d;
            pending_q    <= pending_d;
            err_q        <= err_d;
            busy_q       <= (state_d == ST_CAPTURE);
            row_sel_q    <= row_sel_next;
            col_snake_q  <= col_snake_d;
            col_apple_q  <= col_apple_d;
        end
    end

    assign row_sel_o   = row_sel_q;
    assign col_snake_o = col_snake_q;
    assign col_apple_o = col_apple_q;
    assign busy_o      = busy_q;
    assign frame_err_o = err_q;

endmodule

// File: tb/tb_sga_matrix_renderer.sv
// tb/tb_sga_matrix_renderer.sv - scoreboard bench for sga_matrix_renderer
module tb_sga_matrix_renderer;

    localparam int ROW_HOLD = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       seg_valid = 1'b0;
    logic [5:0] seg_pos = '0;
    logic [5:0] apple_pos = '0;
    logic       frame_done = 1'b0;
    logic [7:0] row_sel, col_snake, col_apple;
    logic       busy, frame_err;

    always #5 clock = ~clock;

    sga_matrix_renderer #(
        .ROW_HOLD (ROW_HOLD),
        .HOLD_W   (16)
    ) dut (
        .clock_i       (clock),
        .reset_n_i     (reset_n),
        .frame_start_i (frame_start),
        .seg_valid_i   (seg_valid),
        .seg_pos_i     (seg_pos),
        .apple_pos_i   (apple_pos),
        .frame_done_i  (frame_done),
        .row_sel_o     (row_sel),
        .col_snake_o   (col_snake),
        .col_apple_o   (col_apple),
        .busy_o        (busy),
        .frame_err_o   (frame_err)
    );

    typedef struct packed {
        logic [7:0][7:0] snake;
        logic [7:0][7:0] apple;
        logic            busy;
        logic            err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   outstanding = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, req);
        end
    endtask

    // Monitor: on each fresh entry into row 0 it takes the next expected
    // frame and compares the whole scan, row by row, plus the hold length.
    logic [7:0] prev_sel = 8'h01;
    int         hold_cnt = 0;
    bit         active = 1'b0;
    int         row_k = 0;
    exp_t       cur;

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_sel = row_sel;
            hold_cnt = 0;
            active   = 1'b0;
        end else begin
            hold_cnt++;
            if (row_sel !== prev_sel) begin
                if (active) begin
                    check($sformatf("hold_row%0d", row_k), 8'(hold_cnt), 8'(ROW_HOLD));
                end else if (row_sel == 8'h01 && exp_q.size() > 0) begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                    row_k  = 0;
                    check("busy", {7'b0, busy}, {7'b0, cur.busy});
                    check("frame_err", {7'b0, frame_err}, {7'b0, cur.err});
                end
                if (active) begin
                    check($sformatf("row_sel_r%0d", row_k), row_sel, 8'h01 << row_k);
                    check($sformatf("col_snake_r%0d", row_k), col_snake, cur.snake[row_k]);
                    check($sformatf("col_apple_r%0d", row_k), col_apple, cur.apple[row_k]);
                    if (row_k == 7) begin
                        active = 1'b0;
                        outstanding--;
                    end else begin
                        row_k++;
                    end
                end
                hold_cnt = 0;
                prev_sel = row_sel;
            end
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic fs, input logic sv, input logic [5:0] sp,
                         input logic fd, input logic [5:0] ap);
        frame_start = fs;
        seg_valid   = sv;
        seg_pos     = sp;
        frame_done  = fd;
        apple_pos   = ap;
        cycle();
        frame_start = 1'b0;
        seg_valid   = 1'b0;
        frame_done  = 1'b0;
        apple_pos   = 6'o56;
    endtask

    task automatic expect_frame(input exp_t e);
        int n;
        exp_q.push_back(e);
        outstanding++;
        n = 0;
        while (outstanding != 0 && n < 150) begin
            cycle();
            n++;
        end
        if (outstanding != 0) begin
            tests++;
            fails++;
            $display("FAIL scan_timeout: %0d scans outstanding, expected 0", outstanding);
            exp_q.delete();
            outstanding = 0;
        end
    endtask

    task automatic sync_wrap();
        int n;
        logic [7:0] p;
        n = 0;
        p = row_sel;
        while (n < 200) begin
            cycle();
            if (p == 8'h80 && row_sel == 8'h01) break;
            p = row_sel;
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL wrap_timeout: row_sel 0x%02h, expected wrap to 0x01", row_sel);
        end
    endtask

    task automatic frame_one();
        drive(1, 0, 6'o00, 0, 6'o00);
        drive(0, 1, 6'o00, 0, 6'o00);
        drive(0, 1, 6'o01, 0, 6'o00);
        drive(0, 1, 6'o11, 1, 6'o33);
        repeat (2) cycle();
    endtask

    exp_t e_zero, e_f1, e_b, e_r, e_r_busy, e_e, e_e_err, e_f1_err;

    initial begin
        e_zero = '0;
        e_f1 = '0;
        e_f1.snake[0] = 8'h03;
        e_f1.snake[1] = 8'h02;
        e_f1.apple[3] = 8'h08;
        e_b = '0;
        e_b.snake[7] = 8'h80;
        e_b.apple[7] = 8'h01;
        e_r = '0;
        e_r.snake[2] = 8'h04;
        e_r.apple[7] = 8'h20;
        e_r_busy = e_r;
        e_r_busy.busy = 1'b1;
        e_e = '0;
        e_e.apple[4] = 8'h10;
        e_e_err = e_e;
        e_e_err.err = 1'b1;
        e_f1_err = e_f1;
        e_f1_err.err = 1'b1;

        repeat (3) cycle();
        check("rst_row_sel", row_sel, 8'h01);
        check("rst_col_snake", col_snake, 8'h00);
        check("rst_col_apple", col_apple, 8'h00);
        check("rst_flags", {6'b0, busy, frame_err}, 8'h00);
        reset_n = 1'b1;
        expect_frame(e_zero);

        // Basic frame, with the segment in the frame_done cycle included.
        frame_one();
        expect_frame(e_f1);

        // Two commits inside one scan: only the newer frame appears.
        sync_wrap();
        drive(1, 0, 6'o00, 0, 6'o00);
        drive(0, 1, 6'o00, 0, 6'o00);
        drive(0, 1, 6'o44, 1, 6'o11);
        repeat (2) cycle();
        drive(1, 0, 6'o00, 0, 6'o00);
        drive(0, 1, 6'o77, 1, 6'o70);
        repeat (2) cycle();
        expect_frame(e_b);

        // Restart mid-capture discards the earlier segments; a segment
        // arriving together with frame_start is dropped.
        drive(1, 0, 6'o00, 0, 6'o00);
        drive(0, 1, 6'o00, 0, 6'o00);
        drive(0, 1, 6'o01, 0, 6'o00);
        drive(1, 1, 6'o33, 0, 6'o00);
        drive(0, 1, 6'o22, 1, 6'o75);
        repeat (2) cycle();
        expect_frame(e_r);

        // frame_start with frame_done while capturing: no error, still busy.
        drive(1, 0, 6'o00, 0, 6'o00);
        drive(1, 0, 6'o00, 1, 6'o00);
        check("start_done_busy", {7'b0, busy}, 8'h01);
        check("start_done_err", {7'b0, frame_err}, 8'h00);
        expect_frame(e_r_busy);
        drive(0, 0, 6'o00, 1, 6'o44);
        repeat (2) cycle();
        expect_frame(e_e);

        // frame_done while idle: sticky error, display unchanged.
        drive(0, 0, 6'o00, 1, 6'o00);
        cycle();
        check("idle_done_err", {7'b0, frame_err}, 8'h01);
        expect_frame(e_e_err);
        frame_one();
        expect_frame(e_f1_err);

        // Asynchronous reset while row 0 shows 0x03.
        sync_wrap();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_row_sel", row_sel, 8'h01);
        check("arst_col_snake", col_snake, 8'h00);
        check("arst_col_apple", col_apple, 8'h00);
        check("arst_flags", {6'b0, busy, frame_err}, 8'h00);
        repeat (3) cycle();
        reset_n = 1'b1;
        expect_frame(e_zero);
        expect_frame(e_zero);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sga_matrix_renderer.md
# sga_matrix_renderer

Downstream consumer of the Snake Game Arcade datapath's render pass. It captures the stream of body positions read out of the snake RAM during rendering, together with the current apple position, into an 8x8 frame. It then drives a row-multiplexed bicolour LED matrix (snake plane, apple plane). Three buffers are used: capture, committed and displayed. A frame is shown only once complete, and it is swapped only at a scan wrap, so the matrix never tears.

## Interface
- ROW_HOLD, 50000, clock cycles each row stays selected (≥2)
- HOLD_W, 16, width of the hold counter (must hold ROW_HOLD-1)

- clock  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  pulse: clear capture buffer, begin a new frame
- seg_valid  in  1  seg_pos holds a body segment this cycle
- seg_pos  in  6  segment position {row[5:3], col[2:0]}
- apple_pos  in  6  apple position {row, col}, sampled at frame_done
- frame_done  in  1  pulse: render pass finished, commit capture
- row_sel  out  8  one-hot active-high row drive
- col_snake  out  8  snake plane columns for the selected row, bit i = col i
- col_apple  out  8  apple plane columns for the selected row
- busy  out  1  capture in progress (state CAPTURE)
- frame_err  out  1  sticky: frame_done received outside CAPTURE

## Operation
- Capture FSM has three states: IDLE, CAPTURE, COMMIT.
  - IDLE: frame_start → CAPTURE, and the capture buffer is cleared. seg_valid is ignored. frame_done sets frame_err and the state stays IDLE.
  - CAPTURE: on seg_valid, set capture[seg_pos[5:3]][seg_pos[2:0]]. On frame_done, go to COMMIT.
  - COMMIT: for one cycle, committed ← capture and apple_reg ← apple_pos latched at frame_done; pending ← 1. Then go to IDLE.
- Simultaneous events:
  - frame_start in any state wins. It clears capture and enters CAPTURE, aborting any partial frame. A commit already in COMMIT still completes.
  - frame_start together with seg_valid: the segment is dropped.
  - frame_start together with frame_done: frame_start wins, and frame_err is not set.
  - seg_valid together with frame_done in CAPTURE: the segment is included.
- Duplicate positions are idempotent (OR semantics).
- Scan: the row index counts 0..7 and wraps. On the wrap edge 7→0, if pending=1, then displayed ← committed, apple_disp ← apple_reg, and pending ← 0. A second commit before the wrap overwrites committed; the newest frame wins.
- Outputs:
  - col_snake = displayed[row].
  - col_apple = one-hot(apple_disp col) when apple_disp row == row, else 0.
  - A cell that is both snake and apple drives both planes.
- frame_err clears only on reset.

## Timing
- Reset values:
  - row_sel = 8'b0000_0001
  - col_snake = 0, col_apple = 0
  - busy = 0, frame_err = 0
  - all buffers = 0, pending = 0, state IDLE
  - row index 0, hold counter 0
  - displayed apple is invalid (col_apple = 0) until the first swap.
- Capture: a bit is set on the edge after seg_valid. Back-to-back seg_valid every cycle is supported.
- Commit: COMMIT is one cycle after frame_done. committed is valid two edges after the frame_done cycle.
- Hold counter counts 0..ROW_HOLD-1. At terminal count the row advances, so each row is held exactly ROW_HOLD cycles and a full scan takes 8·ROW_HOLD cycles.
- row_sel, col_snake and col_apple are registered and change on the same edge. The swap takes effect on the row-0 outputs of that edge.
- Worst-case display latency from frame_done is 2 + 8·ROW_HOLD cycles.
- Asynchronous reset mid-frame discards everything. There is no partial display.

## Structure
- Package sga_render_pkg holds:
  - ROWS=8, COLS=8, POS_W=6
  - capture FSM state encoding (IDLE, CAPTURE, COMMIT)
  - function pos_row/pos_col extraction
- Sub-module sga_row_scan contains the hold counter and row index. It outputs row index, one-hot row_sel_next and a wrap pulse.
- Buffers are 8×8 bit arrays held in flops (no RAM).

## Test plan
- Reset, ROW_HOLD=4: row_sel=0x01, cols=0. Then row_sel advances every 4 cycles, 0x01→0x02→…→0x80→0x01.
- frame_start, seg_pos 6'o00, 6'o01, 6'o11, apple_pos 6'o33, frame_done → after the next wrap:
  - row0 col_snake=0x03
  - row1 col_snake=0x02
  - row3 col_apple=0x08
  - other rows 0.
- Frame A committed, then frame B (seg 6'o77 only) committed before the wrap → after the wrap, only row7 col_snake=0x80. A is never shown.
- frame_start mid-capture after segments 6'o00 and 6'o01, then seg 6'o22, frame_done → row0=0x00, row2=0x04.
- frame_done while IDLE → frame_err=1 and stays 1; display unchanged. frame_start together with frame_done in CAPTURE → frame_err stays 0, busy=1.
- Assert reset_n low mid-scan with frame displayed → all outputs return to reset values asynchronously. After release, display stays blank until a new commit and wrap.
